// File: rtl/vga_pkg.sv
// vga_pkg: shared constants, fetch-state encoding and address helper for the framebuffer fetch
package vga_pkg;
    localparam int DEF_BORDER_CLKS = 64;
    localparam int DEF_COLS        = 32;
    localparam int FIELD_W         = 512;
    localparam int LINE_W          = 640;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;
    function automatic logic [15:0] fb_addr(input logic [1:0] plane, input logic [4:0] col, input logic [7:0] row);
        return {1'b1, plane, col, row};
    endfunction
endpackage

// File: rtl/plane_shifter.sv
// plane_shifter: 8-bit loadable left shift register exposing its MSB
module plane_shifter (
    input  logic       clk24,
    input  logic       reset,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] din,
    output logic       msb
);
    logic [7:0] sr_q, sr_d;
    // load wins over shift; zero fill from the right
    always_comb sr_d = load ? din : shift ? {sr_q[6:0], 1'b0} : sr_q;
    // shift register state
    always_ff @(posedge clk24) sr_q <= reset ? 8'd0 : sr_d;
    assign msb = sr_q[7];
endmodule

// File: rtl/vga_fb_fetch.sv
// vga_fb_fetch: per-line bit-plane fetch and 4-bit pixel serializer with border/blank substitution
module vga_fb_fetch
    import vga_pkg::*;
#(
    parameter int BORDER_CLKS = DEF_BORDER_CLKS,
    parameter int COLS        = DEF_COLS
) (
    input  logic        clk24,
    input  logic        reset,
    input  logic        videoActive,
    input  logic        bordery,
    input  logic        retrace,
    input  logic [8:0]  fb_row,
    input  logic [3:0]  border_idx,
    output logic        rd_req,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    input  logic        rd_ack,
    output logic        pix_active,
    output logic [3:0]  pix_idx,
    output logic        underrun
);
    logic        va_q, fl_q, req_q, req_d, underrun_q, underrun_d, pix_active_q;
    logic        rise, fetch, in_field, load, shift, ack_v, full_now;
    logic [9:0]  hcnt_q, hcnt_d, h, rel;
    logic [7:0]  row_q, row_d;
    logic [1:0]  state_q, state_d, plane_q, plane_d;
    logic [4:0]  col_q, col_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  stage_q [4];
    logic [7:0]  stage_d [4];
    logic [3:0]  pix_q, pix_d, msb;
    logic        unused_row_lsb;

    assign unused_row_lsb = fb_row[0];

    // line tracking: rising edge, horizontal position, fetch-line flag, load/shift strobes
    always_comb begin
        rise     = videoActive & ~va_q;
        h        = rise ? 10'd0 : hcnt_q;
        fetch    = videoActive & (rise ? ~bordery & ~retrace : fl_q);
        row_d    = rise ? fb_row[8:1] : row_q;
        hcnt_d   = !videoActive ? hcnt_q : (h == 10'(LINE_W - 1)) ? h : h + 10'd1;
        rel      = h - 10'(BORDER_CLKS);
        in_field = fetch && rel < 10'(FIELD_W);
        load     = in_field && rel[3:0] == 4'd0 && rel < 10'(16 * COLS);
        shift    = in_field && h[0];
    end

    // an acknowledge only counts while a request is outstanding; the plane-3 ack may coincide with the load
    assign ack_v    = state_q == ST_REQ && req_q && rd_ack;
    assign full_now = state_q == ST_FULL || (ack_v && plane_q == 2'd3);

    // fetch FSM with staging buffer; a load with a column still incomplete aborts and moves on
    always_comb begin
        stage_d = stage_q;
        if (ack_v) stage_d[plane_q] = rd_data;
        state_d    = state_q;
        plane_d    = plane_q;
        col_d      = col_q;
        req_d      = req_q;
        underrun_d = underrun_q;
        if (!videoActive) begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
        end else if (rise) begin
            state_d = fetch ? ST_REQ : ST_IDLE;
            plane_d = 2'd0;
            col_d   = 5'd0;
            req_d   = fetch;
        end else if (load) begin
            underrun_d = underrun_q | (state_q == ST_REQ && !full_now);
            if (state_q == ST_IDLE || col_q == 5'(COLS - 1)) begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end else begin
                state_d = ST_REQ;
                col_d   = col_q + 5'd1;
                plane_d = 2'd0;
                req_d   = 1'b1;
            end
        end else if (ack_v) begin
            if (plane_q == 2'd3) begin
                state_d = ST_FULL;
                req_d   = 1'b0;
            end else begin
                plane_d = plane_q + 2'd1;
            end
        end
        addr_d = (state_d == ST_REQ) ? fb_addr(plane_d, col_d, row_d) : addr_q;
    end

    // request drops combinationally on ack, load abort or end of line so the gap costs no extra cycle
    assign rd_req  = req_q & videoActive & ~ack_v & ~load;
    assign rd_addr = addr_q;

    for (genvar g = 0; g < 4; g++) begin : g_sh
        plane_shifter u_sh (
            .clk24 (clk24),
            .reset (reset),
            .load  (load),
            .shift (shift),
            .din   (stage_d[g]),
            .msb   (msb[g])
        );
    end

    // pixel select: a load cycle already shows the new column's first pixel
    always_comb begin
        pix_d = (!videoActive || retrace) ? 4'd0 :
                load ? {stage_d[3][7], stage_d[2][7], stage_d[1][7], stage_d[0][7]} :
                in_field ? msb : border_idx;
    end

    // state registers; the edge detector is left free-running so reset mid-line does not fake a rise
    always_ff @(posedge clk24) begin
        va_q <= videoActive;
        if (reset) begin
            state_q      <= ST_IDLE;
            plane_q      <= 2'd0;
            col_q        <= 5'd0;
            req_q        <= 1'b0;
            addr_q       <= 16'd0;
            hcnt_q       <= 10'd0;
            fl_q         <= 1'b0;
            row_q        <= 8'd0;
            stage_q      <= '{default: 8'd0};
            underrun_q   <= 1'b0;
            pix_active_q <= 1'b0;
            pix_q        <= 4'd0;
        end else begin
            state_q      <= state_d;
            plane_q      <= plane_d;
            col_q        <= col_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            hcnt_q       <= hcnt_d;
            fl_q         <= fetch;
            row_q        <= row_d;
            stage_q      <= stage_d;
            underrun_q   <= underrun_d;
            pix_active_q <= videoActive;
            pix_q        <= pix_d;
        end
    end

    assign pix_active = pix_active_q;
    assign pix_idx    = pix_q;
    assign underrun   = underrun_q;
endmodule

// File: tb/tb_vga_fb_fetch.sv
// tb_vga_fb_fetch: randomized line-level bench with a behavioural memory and pixel reference
module tb_vga_fb_fetch;
    localparam int B = 64;

    logic        clk24 = 1'b0;
    logic        reset, videoActive, bordery, retrace, rd_ack, rd_req, pix_active, underrun;
    logic [8:0]  fb_row;
    logic [3:0]  border_idx, pix_idx;
    logic [7:0]  rd_data;
    logic [15:0] rd_addr;

    vga_fb_fetch dut (
        .clk24       (clk24),
        .reset       (reset),
        .videoActive (videoActive),
        .bordery     (bordery),
        .retrace     (retrace),
        .fb_row      (fb_row),
        .border_idx  (border_idx),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_ack      (rd_ack),
        .pix_active  (pix_active),
        .pix_idx     (pix_idx),
        .underrun    (underrun)
    );

    always #5 clk24 = ~clk24;

    int          n_cmp = 0, n_bad = 0;
    bit          pend, prev_req, stray;
    int          cnt, req_idx, lat_mode, slow_idx;
    logic [15:0] paddr;
    logic [15:0] acked [$];
    logic        o_req, o_act, o_und;
    logic [15:0] o_addr;
    logic [3:0]  o_pix;
    logic [3:0]  stream [642];
    logic [3:0]  saved [642];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // memory contents: {plane, col} xor row
    function automatic logic [7:0] mem_val(input int p, input int c, input logic [7:0] r);
        return {1'b0, 2'(p), 5'(c)} ^ r;
    endfunction

    // pixel p of the 512-pixel field: 16 clocks per column, 2 clocks per bit, MSB first
    function automatic logic [3:0] ref_pix(input logic [7:0] r, input int p);
        logic [7:0] v;
        logic [3:0] px;
        int c, b;
        c = p / 16;
        b = 7 - (p % 16) / 2;
        for (int pl = 0; pl < 4; pl++) begin
            v = mem_val(pl, c, r);
            px[pl] = v[b];
        end
        return px;
    endfunction

    // one clock: drive inputs and memory ack after the edge, sample outputs on the falling edge
    task automatic step(input bit va, input bit by, input bit rs);
        @(posedge clk24);
        #1;
        videoActive = va;
        bordery     = by;
        reset       = rs;
        rd_ack      = stray;
        stray       = 1'b0;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                rd_ack  = 1'b1;
                rd_data = mem_val(int'(paddr[14:13]), int'(paddr[12:8]), paddr[7:0]);
                pend    = 1'b0;
                acked.push_back(paddr);
            end
        end
        @(negedge clk24);
        o_req  = rd_req;
        o_addr = rd_addr;
        o_act  = pix_active;
        o_pix  = pix_idx;
        o_und  = underrun;
        if (pend && !o_req) pend = 1'b0;
        if (!pend && o_req && !prev_req) begin
            pend    = 1'b1;
            paddr   = o_addr;
            cnt     = (req_idx == slow_idx) ? 4 : (lat_mode == 0) ? int'($urandom_range(3, 1)) : lat_mode;
            req_idx++;
        end
        prev_req = o_req;
    endtask

    task automatic gap();
        repeat (20) step(1'b0, 1'b0, 1'b0);
    endtask

    // a full 640-clock line plus the two surrounding output cycles, checked against the reference
    task automatic run_line(input logic [8:0] row, input bit by, input int lm, input int slow, input bit exp_und);
        int bad_col, req_hi, p;
        logic [3:0] e;
        bad_col  = (slow >= 0) ? slow / 4 : -1;
        fb_row   = row;
        lat_mode = lm;
        slow_idx = slow;
        req_idx  = 0;
        req_hi   = 0;
        acked.delete();
        for (int k = 0; k < 642; k++) begin
            step(k < 640, by, 1'b0);
            req_hi += int'(o_req);
            stream[k] = o_pix;
            p = k - 1 - B;
            e = (k < 1 || k > 640) ? 4'd0 : (!by && p >= 0 && p < 512) ? ref_pix(row[8:1], p) : border_idx;
            chk("pix_active", 32'(o_act), 32'(k >= 1 && k <= 640));
            if (p < 0 || p / 16 != bad_col) chk("pix_idx", 32'(o_pix), 32'(e));
        end
        if (by) chk("bordery_no_req", 32'(req_hi), 32'd0);
        else if (slow < 0) begin
            chk("read_count", 32'(acked.size()), 32'd128);
            foreach (acked[i]) chk("rd_addr", 32'(acked[i]), 32'({1'b1, 2'(i % 4), 5'(i / 4), row[8:1]}));
        end
        chk("underrun", 32'(o_und), 32'(exp_und));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_rd_req", 32'(o_req), 32'd0);
        chk("rst_rd_addr", 32'(o_addr), 32'd0);
        chk("rst_pix_active", 32'(o_act), 32'd0);
        chk("rst_pix_idx", 32'(o_pix), 32'd0);
        chk("rst_underrun", 32'(o_und), 32'd0);
    endtask

    // stimulus sequence
    initial begin
        bit same;
        reset = 1'b1; videoActive = 1'b0; bordery = 1'b0; retrace = 1'b0;
        fb_row = '0; border_idx = '0; rd_data = '0; rd_ack = 1'b0;
        pend = 1'b0; prev_req = 1'b0; stray = 1'b0; lat_mode = 1; slow_idx = -1; req_idx = 0;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk_reset_outputs();
        gap();
        border_idx = 4'($urandom);
        run_line(9'h1FF, 1'b0, 1, -1, 1'b0);
        gap();
        run_line(9'($urandom), 1'b0, 3, -1, 1'b0);
        gap();
        repeat (2) begin
            border_idx = 4'($urandom);
            run_line(9'($urandom), 1'b0, 0, -1, 1'b0);
            gap();
        end
        border_idx = 4'($urandom_range(15, 1));
        run_line(9'($urandom), 1'b1, 0, -1, 1'b0);
        gap();
        run_line(9'($urandom), 1'b0, 3, int'($urandom_range(123, 4)), 1'b1);
        gap();
        run_line(9'($urandom), 1'b0, 0, -1, 1'b1);
        gap();
        // line cut short while a request is up, then a stray acknowledge
        fb_row = 9'($urandom); lat_mode = 3; slow_idx = -1; req_idx = 0;
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0);
        chk("req_before_drop", 32'(o_req), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("req_at_drop", 32'(o_req), 32'd0);
        stray = 1'b1;
        repeat (4) begin
            step(1'b0, 1'b0, 1'b0);
            chk("req_after_stray", 32'(o_req), 32'd0);
        end
        gap();
        run_line(9'($urandom), 1'b0, 0, -1, 1'b1);
        gap();
        // reset in the middle of a fetch line
        fb_row = 9'($urandom); lat_mode = 0; slow_idx = -1; req_idx = 0;
        for (int k = 0; k < 640; k++) begin
            step(1'b1, 1'b0, k == 300);
            if (k == 301) chk_reset_outputs();
        end
        gap();
        run_line(9'($urandom), 1'b0, 0, -1, 1'b0);
        gap();
        // line doubling: both rows map to framebuffer row 80h
        run_line(9'h101, 1'b0, 0, -1, 1'b0);
        saved = stream;
        gap();
        run_line(9'h100, 1'b0, 0, -1, 1'b0);
        same = 1'b1;
        for (int k = 0; k < 642; k++) if (stream[k] !== saved[k]) same = 1'b0;
        chk("double_same", 32'(same), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_fb_fetch.md
# vga_fb_fetch

Per-line framebuffer fetch and pixel serializer. Sits directly downstream of the VGA refresh generator in the 24 MHz video domain. For each active scanline it reads the four Vector-06C bit planes for the current framebuffer row through a request/acknowledge memory port and serializes them into 4-bit palette indices. Border and blanking substitution happen here before the palette stage.

## Interface
- `BORDER_CLKS`, default 64: clocks of horizontal border on each side of the 512-clock pixel field.
- `COLS`, default 32: byte columns per line.
- `clk24`  in  1  video clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `videoActive`  in  1  from the refresh generator; high for 640 clocks per visible line.
- `bordery`  in  1  high on top/bottom border lines; no fetch on these lines.
- `retrace`  in  1  vertical blanking; no fetch, output blanked.
- `fb_row`  in  9  doubled framebuffer row; stable while `videoActive`=1.
- `border_idx`  in  4  palette index used for border pixels.
- `rd_req`  out  1  memory read request.
- `rd_addr`  out  16  byte address = {1'b1, plane[1:0], col[4:0], row[7:0]}.
- `rd_data`  in  8  read data; valid when `rd_ack`=1.
- `rd_ack`  in  1  one-cycle acknowledge; may arrive 1–3 cycles after `rd_req` rises.
- `pix_active`  out  1  registered copy of `videoActive`.
- `pix_idx`  out  4  palette index, {plane3, plane2, plane1, plane0} bit.
- `underrun`  out  1  sticky; a column was loaded before all four planes arrived.

## Operation
- `row` = `fb_row[8:1]`, latched on the rising edge of `videoActive`. Each framebuffer row is therefore shown on two consecutive VGA lines.
- `hcnt` (10 bit) clears on the `videoActive` rising edge, then increments while `videoActive`=1. It saturates at 639.
- Fetch line = `videoActive`, with `bordery`=0 and `retrace`=0 both sampled at the rising edge.
- Fetch FSM:
  - IDLE: on fetch-line rise, `col`←0, `plane`←0, go to REQ.
  - REQ: `rd_req`=1, `rd_addr` held constant. On `rd_ack`, write `rd_data` to `stage[plane]`.
    - If `plane`=3, go to FULL; otherwise `plane`+1 and stay in REQ.
    - `rd_req` drops for at least one cycle between plane reads.
  - FULL: wait for a column load.
    - At a load, if `col`<`COLS`-1: `col`+1, `plane`←0, go to REQ.
    - Otherwise go to IDLE.
- Column load happens at `hcnt` = `BORDER_CLKS` + 16·c, for c = 0..`COLS`-1.
  - All four `stage` bytes copy into the four shift registers.
  - If the FSM is not in FULL at a load: set `underrun`, load current `stage` contents, abort the in-flight read (drop `rd_req`), advance `col`, and restart at plane 0.
- Shifting: shift registers shift left by one on every odd `hcnt` inside the pixel field, giving 2 clocks per pixel and 8 pixels per column.
- Output selection:
  - `pix_idx` = MSBs of the shifters when `hcnt` is in [`BORDER_CLKS`, `BORDER_CLKS`+511] on a fetch line.
  - `pix_idx` = `border_idx` on a non-fetch visible line or outside that `hcnt` range.
  - `pix_idx` = 0 when `videoActive`=0.
- A falling edge of `videoActive` forces the FSM to IDLE and drops `rd_req` in the same cycle, whether or not an acknowledge is pending. A late `rd_ack` is ignored while in IDLE.

## Timing
- Output latency: `pix_active`/`pix_idx` follow `videoActive` by exactly 1 clock. Column c's first pixel appears at `hcnt` = `BORDER_CLKS`+16c+1.
- Line budget:
  - Column 0 prefetch has 64 clocks.
  - Each later column has 16 clocks for 4 reads. With 3-cycle acknowledge plus 1 idle cycle per read, 16 clocks are used exactly, with no slack.
- Reset values:
  - `rd_req`=0, `rd_addr`=0, `pix_active`=0, `pix_idx`=0, `underrun`=0.
  - FSM in IDLE, `hcnt`=0, all shifters and `stage` bytes zero.
- Reset is honoured mid-line and mid-request: `rd_req` is low in the cycle after `reset`.
- `underrun` clears only on `reset`.

## Structure
- Shared package `vga_pkg`:
  - fetch-state encoding (IDLE/REQ/FULL)
  - `BORDER_CLKS`, `COLS`, pixel-field width 512
  - address-composition helper for `rd_addr`
- One sub-module, `plane_shifter`: 8-bit loadable shift register with load/shift enables and an MSB output, instantiated 4×.

## Test plan
- Single fetch line:
  - Stimulus: memory returns byte = {plane, col[4:0]} ^ row with 1-cycle acknowledge; `fb_row`=9'h1FF.
  - Response: 512 pixels match the reference unpack. Addresses are 8000h+{plane,col,FFh}. `underrun`=0.
- Worst-case acknowledge at 3 cycles on every read -> full line correct, `underrun`=0. One acknowledge at 4 cycles -> `underrun`=1 and the following columns are still fetched.
- `bordery`=1 line -> no `rd_req` for the whole line, `pix_idx`=`border_idx` for 640 clocks, 0 elsewhere.
- `videoActive` drops while `rd_req`=1 -> `rd_req`=0 the same cycle. A stray `rd_ack` next cycle causes no state change.
- `reset` asserted at `hcnt`=300 -> next cycle all outputs at reset values. The next fetch line restarts at column 0.
- Doubling: `fb_row`=0x101 then 0x100 -> both lines use `row`=80h and produce identical pixel streams.
